// File: rtl/cva6_hpdcache_req_arbiter_if.sv
// Request/response bundle shared by the HPDcache request arbiter and its
// requesters. The package carries the minimal HPDcache request/response
// types the arbiter needs to see: opcode, source ID and transaction ID.
package cva6_hpdcache_arb_pkg;

    typedef logic [3:0] hpdcache_req_sid_t;
    typedef logic [5:0] hpdcache_req_tid_t;

    typedef enum logic [3:0] {
        HPDCACHE_REQ_LOAD     = 4'd0,
        HPDCACHE_REQ_STORE    = 4'd1,
        HPDCACHE_REQ_CMO      = 4'd2,
        HPDCACHE_REQ_AMO_LR   = 4'd4,
        HPDCACHE_REQ_AMO_SC   = 4'd5,
        HPDCACHE_REQ_AMO_SWAP = 4'd6,
        HPDCACHE_REQ_AMO_ADD  = 4'd7,
        HPDCACHE_REQ_AMO_AND  = 4'd8,
        HPDCACHE_REQ_AMO_OR   = 4'd9,
        HPDCACHE_REQ_AMO_XOR  = 4'd10,
        HPDCACHE_REQ_AMO_MAX  = 4'd11,
        HPDCACHE_REQ_AMO_MAXU = 4'd12,
        HPDCACHE_REQ_AMO_MIN  = 4'd13,
        HPDCACHE_REQ_AMO_MINU = 4'd14
    } hpdcache_req_op_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [31:0]       wdata;
        hpdcache_req_op_t  op;
        logic [3:0]        be;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        hpdcache_req_sid_t sid;
        hpdcache_req_tid_t tid;
        logic              error;
    } hpdcache_rsp_t;

endpackage

interface cva6_hpdcache_req_arbiter_if
    import cva6_hpdcache_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3
) ();

    logic [NREQ-1:0] core_req_valid;
    logic [NREQ-1:0] core_req_ready;
    hpdcache_req_t   core_req [NREQ];
    logic [NREQ-1:0] core_rsp_valid;
    hpdcache_rsp_t   core_rsp [NREQ];

    logic            dcache_req_valid;
    logic            dcache_req_ready;
    hpdcache_req_t   dcache_req;
    logic            dcache_rsp_valid;
    hpdcache_rsp_t   dcache_rsp;

    // Arbiter side
    modport slave (
        input  core_req_valid, core_req, dcache_req_ready, dcache_rsp_valid, dcache_rsp,
        output core_req_ready, core_rsp_valid, core_rsp, dcache_req_valid, dcache_req
    );

    // Requester / cache side
    modport master (
        output core_req_valid, core_req, dcache_req_ready, dcache_rsp_valid, dcache_rsp,
        input  core_req_ready, core_rsp_valid, core_rsp, dcache_req_valid, dcache_req
    );

endinterface

// File: rtl/cva6_hpdcache_req_arbiter.sv
// Round-robin arbiter sharing one HPDcache core port among NREQ requesters.
// Forwarded requests carry a per-port source ID; responses are routed back
// by that ID. A stalled grant is held until accepted, and an accepted AMO
// blocks all further requests until its final response (tid all ones) is seen.
module cva6_hpdcache_req_arbiter
    import cva6_hpdcache_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned SID_BASE = 0
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    cva6_hpdcache_req_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t next_idx(input idx_t i);
        return (32'(i) == NREQ - 1) ? '0 : idx_t'(32'(i) + 32'd1);
    endfunction

    function automatic hpdcache_req_sid_t sid_of(input idx_t i);
        return hpdcache_req_sid_t'(SID_BASE + 32'(i));
    endfunction

    function automatic logic is_amo(input hpdcache_req_op_t op);
        case (op)
            HPDCACHE_REQ_AMO_LR,  HPDCACHE_REQ_AMO_SC,  HPDCACHE_REQ_AMO_SWAP,
            HPDCACHE_REQ_AMO_ADD, HPDCACHE_REQ_AMO_AND, HPDCACHE_REQ_AMO_OR,
            HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX, HPDCACHE_REQ_AMO_MAXU,
            HPDCACHE_REQ_AMO_MIN, HPDCACHE_REQ_AMO_MINU: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    idx_t rr_ptr_q;
    idx_t hold_idx_q;
    idx_t lock_idx_q;
    logic hold_q;
    logic lock_q;

    idx_t grant_idx;
    idx_t cand;
    logic search_hit;
    logic grant_valid;
    logic grant_hs;
    logic lock_release;
    logic rsp_sid_ok;

    // Pick the granted port: sticky port while held, else first valid from rr_ptr_q
    always_comb begin
        grant_idx  = rr_ptr_q;
        cand       = '0;
        search_hit = 1'b0;
        if (hold_q) begin
            grant_idx = hold_idx_q;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = idx_t'((32'(rr_ptr_q) + i) % NREQ);
                if (!search_hit && bus.core_req_valid[cand]) begin
                    grant_idx  = cand;
                    search_hit = 1'b1;
                end
            end
        end
    end

    assign grant_valid = !lock_q && bus.core_req_valid[grant_idx];
    assign grant_hs    = grant_valid && bus.dcache_req_ready;

    // The final AMO response from the locking port reopens arbitration next cycle
    assign lock_release = bus.dcache_rsp_valid && (&bus.dcache_rsp.tid)
                          && (bus.dcache_rsp.sid == sid_of(lock_idx_q));

    // Forward the granted request with its source ID; only the granted port sees ready
    always_comb begin
        bus.core_req_ready            = '0;
        bus.core_req_ready[grant_idx] = grant_hs;
        bus.dcache_req_valid          = grant_valid;
        bus.dcache_req                = bus.core_req[grant_idx];
        bus.dcache_req.sid            = sid_of(grant_idx);
    end

    // Route responses by source ID; never back-pressured, out-of-range IDs match nothing
    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            bus.core_rsp_valid[k] = bus.dcache_rsp_valid
                                    && (bus.dcache_rsp.sid == sid_of(idx_t'(k)));
            bus.core_rsp[k]       = bus.dcache_rsp;
        end
    end

    // Arbitration control state: round-robin pointer, grant hold and AMO lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            hold_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            if (grant_hs) begin
                rr_ptr_q <= next_idx(grant_idx);
                hold_q   <= 1'b0;
                if (is_amo(bus.core_req[grant_idx].op)) begin
                    lock_q <= 1'b1;
                end
            end else if (grant_valid) begin
                hold_q <= 1'b1;
            end
            if (lock_q && lock_release) begin
                lock_q <= 1'b0;
            end
        end
    end

    // Port indices qualifying hold/lock; only meaningful while their flag is set
    always_ff @(posedge clk_i) begin
        if (grant_valid && !bus.dcache_req_ready) begin
            hold_idx_q <= grant_idx;
        end
        if (grant_hs && is_amo(bus.core_req[grant_idx].op)) begin
            lock_idx_q <= grant_idx;
        end
    end

    assign rsp_sid_ok = (32'(bus.dcache_rsp.sid) - SID_BASE) < NREQ;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.core_req_ready));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        hold_q |-> (bus.dcache_req_valid && $stable(bus.dcache_req)));

    a_hold_lock_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hold_q && lock_q));

    a_rsp_sid_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.dcache_rsp_valid |-> rsp_sid_ok)
        else $warning("response with sid %0d outside this arbiter's range was dropped",
                      bus.dcache_rsp.sid);

endmodule
